// File: rtl/fft_pkg.sv
// Shared constants, stream payload layout and FSM encoding for the FFT spectrum sink.
package fft_pkg;

  localparam int unsigned FFT_LEN      = 1024;
  localparam int unsigned IDX_WIDTH    = 10;
  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned BANDS        = 32;
  localparam int unsigned MAG_WIDTH    = 32;
  localparam int unsigned FLUSH_CYCLES = 3;

  // 16 positive-frequency bins fold into each display band
  localparam int unsigned BIN_SHIFT    = 4;
  localparam int unsigned BAND_WIDTH   = 5;

  // XFFT m_axis_data tdata layout
  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0] im;
    logic signed [SAMPLE_WIDTH-1:0] re;
  } fft_sample_t;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SWAP   = 2'd2
  } fft_state_e;

endpackage

// File: rtl/mag_sq_pipe.sv
// Three-stage |X|^2 pipeline: register inputs, square each component, sum.
module mag_sq_pipe
  import fft_pkg::*;
(
  input  logic                           clk_50mhz,
  input  logic                           reset,
  input  logic                           beat_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] beat_re,
  input  logic signed [SAMPLE_WIDTH-1:0] beat_im,
  input  logic [IDX_WIDTH-1:0]           beat_idx,
  input  logic                           beat_last,
  output logic                           mag_valid,
  output logic [MAG_WIDTH-1:0]           mag,
  output logic [IDX_WIDTH-1:0]           mag_idx,
  output logic                           mag_last
);

  // A square of a 16-bit signed value never exceeds 2^30, so 31 bits hold it
  localparam int unsigned SQ_WIDTH = 2 * SAMPLE_WIDTH - 1;

  logic                           s1_valid;
  logic signed [SAMPLE_WIDTH-1:0] s1_re;
  logic signed [SAMPLE_WIDTH-1:0] s1_im;
  logic [IDX_WIDTH-1:0]           s1_idx;
  logic                           s1_last;

  logic                           s2_valid;
  logic [SQ_WIDTH-1:0]            s2_re_sq;
  logic [SQ_WIDTH-1:0]            s2_im_sq;
  logic [IDX_WIDTH-1:0]           s2_idx;
  logic                           s2_last;

  logic signed [SQ_WIDTH-1:0]     re_ext;
  logic signed [SQ_WIDTH-1:0]     im_ext;

  // Sign-extend before multiplying so the product is formed at result width
  assign re_ext = SQ_WIDTH'(s1_re);
  assign im_ext = SQ_WIDTH'(s1_im);

  // S1: capture the accepted beat
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= beat_valid;
      s1_re    <= beat_re;
      s1_im    <= beat_im;
      s1_idx   <= beat_idx;
      s1_last  <= beat_last & beat_valid;
    end
  end

  // S2: component squares
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_re_sq <= '0;
      s2_im_sq <= '0;
      s2_idx   <= '0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_re_sq <= re_ext * re_ext;
      s2_im_sq <= im_ext * im_ext;
      s2_idx   <= s1_idx;
      s2_last  <= s1_last;
    end
  end

  // S3: zero-extended sum, at most 2^31 so it cannot overflow
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      mag_valid <= 1'b0;
      mag       <= '0;
      mag_idx   <= '0;
      mag_last  <= 1'b0;
    end else begin
      mag_valid <= s2_valid;
      mag       <= MAG_WIDTH'(s2_re_sq) + MAG_WIDTH'(s2_im_sq);
      mag_idx   <= s2_idx;
      mag_last  <= s2_last;
    end
  end

endmodule

// File: rtl/fft_spectrum_sink.sv
// XFFT output sink: per-band |X|^2 maxima into a double-buffered bank set
// that the LED column scan reads through a registered port.
module fft_spectrum_sink
  import fft_pkg::*;
(
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic [15:0] s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        err_tlast
);

  fft_state_e                state;
  fft_state_e                state_d;
  logic [1:0]                flush_cnt;
  logic [1:0]                flush_cnt_d;

  fft_sample_t               beat;
  logic [IDX_WIDTH-1:0]      beat_idx;
  logic                      beat_xfer;
  logic                      idx_is_end;
  logic                      frame_end;

  logic                      mag_valid;
  logic [MAG_WIDTH-1:0]      mag;
  logic [IDX_WIDTH-1:0]      mag_idx;
  logic                      mag_last;
  logic                      mag_in_range;
  logic [BAND_WIDTH-1:0]     mag_band;

  logic [MAG_WIDTH-1:0]      bank [2][BANDS];
  logic                      bank_sel;
  logic                      wr_sel;

  assign beat = s_axis_tdata;
  // tuser upper bits are reserved zero; only XK_INDEX is meaningful
  assign beat_idx   = IDX_WIDTH'(s_axis_tuser);
  assign beat_xfer  = s_axis_tvalid & s_axis_tready;
  assign idx_is_end = (beat_idx == IDX_WIDTH'(FFT_LEN - 1));
  assign frame_end  = beat_xfer & (s_axis_tlast | idx_is_end);

  assign wr_sel       = ~bank_sel;
  assign mag_in_range = (mag_idx < IDX_WIDTH'(FFT_LEN / 2));
  assign mag_band     = mag_idx[BIN_SHIFT +: BAND_WIDTH];

  mag_sq_pipe u_mag_sq_pipe (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .beat_valid (beat_xfer),
    .beat_re    (beat.re),
    .beat_im    (beat.im),
    .beat_idx   (beat_idx),
    .beat_last  (frame_end),
    .mag_valid  (mag_valid),
    .mag        (mag),
    .mag_idx    (mag_idx),
    .mag_last   (mag_last)
  );

  // State register; tready is registered from the next state so it tracks ACCEPT exactly
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state         <= ST_ACCEPT;
      flush_cnt     <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_d;
      flush_cnt     <= flush_cnt_d;
      s_axis_tready <= (state_d == ST_ACCEPT);
    end
  end

  // Next-state logic: accept a frame, drain the pipeline, then publish
  always_comb begin
    state_d     = state;
    flush_cnt_d = flush_cnt;
    case (state)
      ST_ACCEPT: begin
        flush_cnt_d = '0;
        if (frame_end) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt + 2'd1;
        // the count and the last beat leaving S3 coincide; either closes the drain
        if ((flush_cnt == 2'(FLUSH_CYCLES - 1)) || mag_last) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_d = ST_ACCEPT;
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // Status outputs: publish pulse, frame counter, tlast/index mismatch
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_tlast   <= 1'b0;
    end else begin
      frame_done <= (state == ST_SWAP);
      err_tlast  <= beat_xfer & (s_axis_tlast ^ idx_is_end);
      if (state == ST_SWAP) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Band maxima into the write bank; on SWAP the old read bank becomes the cleared write bank
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      bank_sel <= 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < BANDS; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else begin
      if (mag_valid && mag_in_range && (mag > bank[wr_sel][mag_band])) begin
        bank[wr_sel][mag_band] <= mag;
      end
      if (state == ST_SWAP) begin
        bank_sel <= wr_sel;
        for (int unsigned i = 0; i < BANDS; i++) begin
          bank[bank_sel][i] <= '0;
        end
      end
    end
  end

  // Registered read port; during SWAP it already reads the bank being published
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      rd_data <= '0;
    end else if (state == ST_SWAP) begin
      rd_data <= bank[wr_sel][rd_addr];
    end else begin
      rd_data <= bank[bank_sel][rd_addr];
    end
  end

endmodule
